// File: rtl/aes_pkg.sv
// Shared AES types, state-machine encoding and the FIPS-197 substitution tables.
package aes_pkg;

    typedef logic [7:0]   aes_byte_t;
    typedef logic [0:127] aes_state_t;

    localparam int NB = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam aes_byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam aes_byte_t INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/aes_sub_bytes_iter_if.sv
// Block-level valid/ready bus between the round datapath and the SubBytes stage.
interface aes_sub_bytes_iter_if;
    import aes_pkg::*;

    logic       in_valid;
    logic       in_ready;
    logic       in_inv;
    aes_state_t in_data;
    logic       out_valid;
    logic       out_ready;
    aes_state_t out_data;

    modport master (
        output in_valid, in_inv, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_inv, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/aes_sbox.sv
// One combinational S-box lane; inv selects the inverse table.
module aes_sbox
    import aes_pkg::*;
(
    input  aes_byte_t byte_in,
    input  logic      inv,
    output aes_byte_t byte_out
);
    assign byte_out = inv ? INV_SBOX[byte_in] : SBOX[byte_in];
endmodule

// File: rtl/aes_sub_bytes_iter.sv
// Iterative SubBytes/InvSubBytes: LANES shared S-boxes rewrite the held state in place,
// one group of bytes per cycle, then present the block until downstream takes it.
module aes_sub_bytes_iter
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    aes_sub_bytes_iter_if.slave  bus
);
    localparam int NCYC  = NB / LANES;
    localparam int CNT_W = (NCYC > 1) ? $clog2(NCYC) : 1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    aes_state_t       work_q, work_d;
    logic             inv_q, inv_d;
    logic             accept;
    logic             last;
    logic [6:0]       bit_base;
    aes_byte_t        lane_in  [LANES];
    aes_byte_t        lane_out [LANES];

    assign accept   = bus.in_valid & bus.in_ready;
    assign last     = (cnt_q == CNT_W'(NCYC - 1));
    assign bit_base = 7'(int'(cnt_q) * LANES * 8);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_in[i] = work_q[bit_base + 7'(8 * i) +: 8];
        aes_sbox u_sbox (
            .byte_in  (lane_in[i]),
            .inv      (inv_q),
            .byte_out (lane_out[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.in_valid) state_d = ST_BUSY;
            ST_BUSY: if (last) state_d = ST_DONE;
            ST_DONE: if (bus.out_ready) state_d = bus.in_valid ? ST_BUSY : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready in DONE lets a new block load on the same edge the old one is consumed
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (state_q)
            ST_IDLE: bus.in_ready = 1'b1;
            ST_DONE: begin
                bus.out_valid = 1'b1;
                bus.in_ready  = bus.out_ready;
            end
            default: ;
        endcase
    end

    assign bus.out_data = work_q;

    always_comb begin
        work_d = work_q;
        inv_d  = inv_q;
        cnt_d  = cnt_q;
        if (accept) begin
            work_d = bus.in_data;
            inv_d  = bus.in_inv;
            cnt_d  = '0;
        end else if (state_q == ST_BUSY) begin
            for (int i = 0; i < LANES; i++) begin
                work_d[bit_base + 7'(8 * i) +: 8] = lane_out[i];
            end
            cnt_d = last ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q <= '0;
            inv_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            work_q <= work_d;
            inv_q  <= inv_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: tb/tb_aes_sub_bytes_iter.sv
// Bench for aes_sub_bytes_iter: a GF(2^8)-derived S-box model and a transaction-level
// scoreboard check every cycle, plus directed FIPS-197 and handshake cases.
module tb_aes_sub_bytes_iter;
    import aes_pkg::*;

    localparam int LANES = 4;
    localparam int NCYC  = 16 / LANES;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    aes_sub_bytes_iter_if bus_if ();

    aes_sub_bytes_iter #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    aes_byte_t m_sbox [256];
    aes_byte_t m_inv  [256];

    function automatic aes_byte_t gmul(input aes_byte_t a, input aes_byte_t b);
        aes_byte_t p = 8'h00;
        logic      hi;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic aes_byte_t rotl(input aes_byte_t b, input int n);
        return 8'((b << n) | (b >> (8 - n)));
    endfunction

    function automatic aes_byte_t model_sbox(input aes_byte_t x);
        aes_byte_t r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic aes_state_t model_sub(input aes_state_t s, input logic inv);
        aes_state_t r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = inv ? m_inv[s[8*k +: 8]] : m_sbox[s[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: at most one pending block, visible NCYC edges after its accept edge
    bit         pend = 0;
    aes_state_t pend_data;
    int         pend_rdy;
    int         cyc = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 0;
        end else begin
            bit ov, ir;
            ov = pend && (cyc >= pend_rdy);
            ir = !pend || (ov && bus_if.out_ready);
            if (ov && bus_if.out_ready) pend = 0;
            cyc++;
            if (bus_if.in_valid && ir) begin
                pend      = 1;
                pend_data = model_sub(bus_if.in_data, bus_if.in_inv);
                pend_rdy  = cyc + NCYC;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", bus_if.out_valid, 0);
            chk("rst_out_data", bus_if.out_data, 0);
        end else begin
            bit ov, ir;
            ov = pend && (cyc >= pend_rdy);
            ir = !pend || (ov && bus_if.out_ready);
            chk("out_valid", bus_if.out_valid, ov);
            chk("in_ready", bus_if.in_ready, ir);
            if (ov) chk("out_data", bus_if.out_data, pend_data);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string nm, output int lat);
        lat = 0;
        while (!bus_if.out_valid && lat < 50) begin
            step();
            lat++;
        end
        if (!bus_if.out_valid) chk({nm, "_timeout"}, 0, 1);
    endtask

    task automatic wait_in_ready(input string nm);
        int t = 0;
        while (!bus_if.in_ready && t < 50) begin
            step();
            t++;
        end
        if (!bus_if.in_ready) chk({nm, "_ready_timeout"}, 0, 1);
    endtask

    task automatic run_block(input aes_state_t d, input logic inv, input aes_state_t exp,
                             input string nm);
        int lat;
        bus_if.out_ready = 1'b0;
        bus_if.in_valid  = 1'b1;
        bus_if.in_data   = d;
        bus_if.in_inv    = inv;
        wait_in_ready(nm);
        step();
        bus_if.in_valid = 1'b0;
        bus_if.in_inv   = ~inv;
        wait_valid(nm, lat);
        chk({nm, "_latency"}, lat, NCYC);
        chk({nm, "_data"}, bus_if.out_data, exp);
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
    endtask

    function automatic aes_state_t rand_state();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        aes_state_t appb_in, appb_out, ones63, zeros, b53, exp53, held;
        int lat;
        int acc [4];
        int n, t;

        for (int i = 0; i < 256; i++) m_sbox[i] = model_sbox(8'(i));
        for (int i = 0; i < 256; i++) m_inv[m_sbox[i]] = 8'(i);

        appb_in  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
        appb_out = 128'hd42711aee0bf98f1b8b45de51e415230;
        zeros    = '0;
        ones63   = {16{8'h63}};
        b53      = {8'h53, 120'h0};
        exp53    = {8'hed, {15{8'h63}}};

        chk("model_sbox_00", m_sbox[0], 8'h63);
        chk("model_sbox_53", m_sbox[8'h53], 8'hed);
        chk("model_inv_63", m_inv[8'h63], 8'h00);
        chk("model_appb", model_sub(appb_in, 1'b0), appb_out);
        chk("model_appb_inv", model_sub(appb_out, 1'b1), appb_in);

        bus_if.in_valid  = 1'b0;
        bus_if.in_inv    = 1'b0;
        bus_if.in_data   = '0;
        bus_if.out_ready = 1'b0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) step();
        rst_n = 1'b1;
        chk("reset_in_ready", bus_if.in_ready, 1);
        chk("reset_out_valid", bus_if.out_valid, 0);
        chk("reset_out_data", bus_if.out_data, 0);

        run_block(appb_in, 1'b0, appb_out, "appb_fwd");
        run_block(appb_out, 1'b1, appb_in, "appb_inv");
        run_block(zeros, 1'b0, ones63, "zeros_fwd");
        run_block(ones63, 1'b1, zeros, "ones63_inv");
        run_block(b53, 1'b0, exp53, "byte53_fwd");

        // Backpressure: block held for 10 cycles
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = rand_state();
        bus_if.in_inv   = 1'b0;
        wait_in_ready("bp");
        step();
        wait_valid("bp", lat);
        held = bus_if.out_data;
        bus_if.in_data = rand_state();
        for (int i = 0; i < 10; i++) begin
            chk("bp_valid", bus_if.out_valid, 1);
            chk("bp_stable", bus_if.out_data, held);
            chk("bp_in_ready", bus_if.in_ready, 0);
            step();
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        step();
        bus_if.out_ready = 1'b0;
        chk("bp_consumed_valid", bus_if.out_valid, 0);
        chk("bp_idle_ready", bus_if.in_ready, 1);

        // Back-to-back throughput
        bus_if.in_valid  = 1'b1;
        bus_if.out_ready = 1'b1;
        n = 0;
        t = 0;
        while (n < 4 && t < 60) begin
            bus_if.in_data = rand_state();
            bus_if.in_inv  = 1'($urandom_range(0, 1));
            if (bus_if.in_ready) begin
                acc[n] = t;
                n++;
            end
            step();
            t++;
        end
        chk("b2b_accepts", n, 4);
        for (int i = 0; i < 3; i++)
            if (i + 1 < n) chk("b2b_interval", acc[i+1] - acc[i], NCYC + 1);
        bus_if.in_valid = 1'b0;
        repeat (NCYC + 2) step();
        bus_if.out_ready = 1'b0;

        // Reset in BUSY cycle 2
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = rand_state();
        wait_in_ready("rst_busy");
        step();
        bus_if.in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("rst_busy_out_valid", bus_if.out_valid, 0);
        step();
        rst_n = 1'b1;
        chk("rst_busy_in_ready", bus_if.in_ready, 1);
        run_block(appb_in, 1'b0, appb_out, "after_rst_busy");

        // Reset while holding a finished block
        bus_if.in_valid = 1'b1;
        bus_if.in_data  = rand_state();
        wait_in_ready("rst_done");
        step();
        bus_if.in_valid = 1'b0;
        wait_valid("rst_done", lat);
        rst_n = 1'b0;
        #1;
        chk("rst_done_out_valid", bus_if.out_valid, 0);
        chk("rst_done_out_data", bus_if.out_data, 0);
        step();
        rst_n = 1'b1;
        chk("rst_done_in_ready", bus_if.in_ready, 1);
        run_block(appb_out, 1'b1, appb_in, "after_rst_done");

        // Randomized traffic, checked cycle by cycle by the scoreboard
        for (int i = 0; i < 400; i++) begin
            bus_if.in_valid  = 1'($urandom_range(0, 1));
            bus_if.in_inv    = 1'($urandom_range(0, 1));
            bus_if.in_data   = rand_state();
            bus_if.out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        repeat (NCYC + 3) step();
        chk("drain_idle", bus_if.in_ready, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
